// File: rtl/gray_pkg.sv
// Shared definitions for Gray-sequenced counters and pointer logic.
// bin2gray works on a 32-bit vector; callers zero-extend and slice to their width.
package gray_pkg;

    localparam int COUNT_WRAP = 0;
    localparam int COUNT_SAT  = 1;
    localparam int MAX_WIDTH  = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter using a prefix-XOR chain from the MSB.
// Also used by async FIFO pointer synchronisers.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic acc_s;

    // Running XOR from the MSB down: bin[i] = ^gray[WIDTH-1:i]
    always_comb begin
        bin   = {WIDTH{1'b0}};
        acc_s = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc_s  = acc_s ^ gray[i];
            bin[i] = acc_s;
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter keeping a binary count and its registered Gray image in lock-step,
// with binary/Gray load, wrap-or-saturate limits, terminal count and wrap pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               SATURATE  = COUNT_WRAP,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             tc,
    output logic             wrap_pulse
);

    localparam bit                   SAT_MODE        = (SATURATE == COUNT_SAT);
    localparam logic [WIDTH-1:0]     ALL_ONES        = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]     ALL_ZERO        = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     ONE             = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAX_WIDTH-1:0] RESET_GRAY_FULL = bin2gray(MAX_WIDTH'(RESET_VAL));
    localparam logic [WIDTH-1:0]     RESET_GRAY      = RESET_GRAY_FULL[WIDTH-1:0];

    logic [WIDTH-1:0]     bin_d;
    logic [WIDTH-1:0]     gray_d;
    logic                 wrap_d;
    logic                 wrap_q;
    logic [WIDTH-1:0]     load_conv_s;
    logic [MAX_WIDTH-1:0] gray_full_s;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray (load_val),
        .bin  (load_conv_s)
    );

    assign tc         = (up & (bin_q == ALL_ONES)) | (~up & (bin_q == ALL_ZERO));
    assign wrap_pulse = wrap_q;

    // Next-count selection: load beats en; at a limit either wrap (with pulse) or hold
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_gray ? load_conv_s : load_val;
        end else if (en) begin
            if (tc && SAT_MODE) begin
                bin_d = bin_q;
            end else begin
                bin_d  = up ? (bin_q + ONE) : (bin_q - ONE);
                wrap_d = tc;
            end
        end else begin
            bin_d = bin_q;
        end
    end

    // Gray image is derived from the next binary value so both flops update together
    always_comb begin
        gray_full_s = bin2gray(MAX_WIDTH'(bin_d));
        gray_d      = gray_full_s[WIDTH-1:0];
    end

    // Count, Gray and wrap-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a wrapping and a saturating instance share stimulus.
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic       load_gray;
    logic [3:0] load_val;

    logic [3:0] bin_w, gray_w, bin_s, gray_s;
    logic       tc_w, tc_s, wrap_w, wrap_s;

    typedef struct {
        string      tag;
        logic [3:0] wb;
        logic [3:0] wg;
        logic       ww;
        logic [3:0] sb;
        logic [3:0] sg;
        logic       sw;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp;
    int         n_err;
    logic [3:0] m_w;
    logic [3:0] m_s;
    logic [3:0] prev_gw;
    logic [3:0] gseq [16];

    gray_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'b0000)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_q(bin_w), .gray_q(gray_w), .tc(tc_w), .wrap_pulse(wrap_w)
    );

    gray_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'b0000)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_q(bin_s), .gray_q(gray_s), .tc(tc_s), .wrap_pulse(wrap_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [3:0] m_gray(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    function automatic logic m_tc(input logic [3:0] b, input logic u);
        return u ? (b == 4'hF) : (b == 4'h0);
    endfunction

    // Reference next-state: returns {wrap, next_bin}
    function automatic logic [4:0] m_next(input logic [3:0] b, input logic sat, input logic e,
                                          input logic u, input logic l, input logic lg,
                                          input logic [3:0] lv);
        logic [3:0] nb;
        logic       w;
        nb = b;
        w  = 1'b0;
        if (l) begin
            nb = lg ? m_g2b(lv) : lv;
        end else if (e) begin
            if (m_tc(b, u) && sat) begin
                nb = b;
            end else begin
                nb = u ? b + 4'd1 : b - 4'd1;
                w  = m_tc(b, u);
            end
        end
        return {w, nb};
    endfunction

    task automatic step(input string tag, input logic e, input logic u, input logic l,
                        input logic lg, input logic [3:0] lv);
        exp_t       x;
        exp_t       y;
        logic [4:0] rw;
        logic [4:0] rs;
        en = e; up = u; load = l; load_gray = lg; load_val = lv;
        #1;
        check_val({tag, ":tc_w"}, 32'(tc_w), 32'(m_tc(m_w, u)));
        check_val({tag, ":tc_s"}, 32'(tc_s), 32'(m_tc(m_s, u)));
        rw = m_next(m_w, 1'b0, e, u, l, lg, lv);
        rs = m_next(m_s, 1'b1, e, u, l, lg, lv);
        x.tag = tag;
        x.wb = rw[3:0]; x.wg = m_gray(rw[3:0]); x.ww = rw[4];
        x.sb = rs[3:0]; x.sg = m_gray(rs[3:0]); x.sw = rs[4];
        exp_q.push_back(x);
        m_w = rw[3:0];
        m_s = rs[3:0];
        @(posedge clk);
        #1;
        y = exp_q.pop_front();
        check_val({y.tag, ":bin_w"},  32'(bin_w),  32'(y.wb));
        check_val({y.tag, ":gray_w"}, 32'(gray_w), 32'(y.wg));
        check_val({y.tag, ":wrap_w"}, 32'(wrap_w), 32'(y.ww));
        check_val({y.tag, ":bin_s"},  32'(bin_s),  32'(y.sb));
        check_val({y.tag, ":gray_s"}, 32'(gray_s), 32'(y.sg));
        check_val({y.tag, ":wrap_s"}, 32'(wrap_s), 32'(y.sw));
        if (e && !l) begin
            check_val({y.tag, ":hamming_w"}, 32'($countones(prev_gw ^ gray_w)), 32'd1);
        end
        prev_gw = gray_w;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ":bin_w"},  32'(bin_w),  32'd0);
        check_val({tag, ":gray_w"}, 32'(gray_w), 32'd0);
        check_val({tag, ":wrap_w"}, 32'(wrap_w), 32'd0);
        check_val({tag, ":bin_s"},  32'(bin_s),  32'd0);
        check_val({tag, ":gray_s"}, 32'(gray_s), 32'd0);
        check_val({tag, ":wrap_s"}, 32'(wrap_s), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_w = 4'h0;
        m_s = 4'h0;
        prev_gw = 4'h0;
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0; load_val = 4'h0;

        // Reset values
        #12;
        check_reset("reset");
        check_val("reset:tc_w", 32'(tc_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Count up through a wrap, checking the literal Gray sequence
        for (int i = 0; i < 16; i++) begin
            step("up", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
            check_val("up:gseq", 32'(gray_w), 32'(gseq[i]));
        end
        check_val("up:wrap_after", 32'(wrap_w), 32'd1);
        step("up_post", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        check_val("up_post:wrap_clear", 32'(wrap_w), 32'd0);

        // Count down through a wrap
        step("ld0", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        step("dn_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        check_val("dn_wrap:gray", 32'(gray_w), 32'(4'b1000));
        step("dn_next", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        check_val("dn_next:gray", 32'(gray_w), 32'(4'b1001));

        // Saturate at all-ones, then reverse out
        step("ldF", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) step("sat_up", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        check_val("sat_up:bin_s", 32'(bin_s), 32'hF);
        step("sat_rev", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        check_val("sat_rev:bin_s", 32'(bin_s), 32'hE);

        // Loads with en held
        step("ld_gray", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        check_val("ld_gray:bin", 32'(bin_w), 32'(4'b0100));
        step("ld_bin", 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010);
        check_val("ld_bin:gray", 32'(gray_w), 32'(4'b1111));
        step("ld_F", 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
        step("ld_at_tc", 1'b1, 1'b1, 1'b1, 1'b0, 4'h3);
        check_val("ld_at_tc:wrap", 32'(wrap_w), 32'd0);

        // Reset mid-count between edges
        step("ld4", 1'b0, 1'b1, 1'b1, 1'b0, 4'h4);
        step("to5", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        m_w = 4'h0;
        m_s = 4'h0;
        prev_gw = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step("restart", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        check_val("restart:bin", 32'(bin_w), 32'd1);

        // Random mix
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
